seq_det_rr_scheduler: RTL

SEQ_DET_RR_SCHEDULER -- requirements
Module: seq_det_rr_scheduler

---
 rtl/seq_det_rr_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_det_rr_scheduler.sv
// seq_det_rr_scheduler: one "10X0" overlapping Moore detector next-state
// function shared round-robin across 4 channels. Each channel keeps its own
// 3-bit stored state and a saturating detection counter.
//
// Handshake: a channel raises Req[ch] with its serial bit on Din[ch] and holds
// both stable until Gnt[ch] is seen high; the rising edge on which Gnt[ch] is
// high consumes the bit (state and counter update, pointer moves to ch).
// Gnt is combinational, at most one bit high, and is zero during reset.
`timescale 1ns/1ps
module seq_det_rr_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Req,
  input  logic [3:0]       Din,
  input  logic [3:0]       Ch_En,
  input  logic [1:0]       Cnt_Sel,
  input  logic             Cnt_Clr,
  output logic [3:0]       Gnt,
  output logic [3:0]       OP,
  output logic [1:0]       Gnt_Ch,
  output logic [2:0]       CS,
  output logic [2:0]       NS,
  output logic [CNT_W-1:0] Cnt_Out
);

  // Stored channel state; the unused code 111 is treated like S0.
  typedef enum logic [2:0] {
    S0    = 3'b000,
    S1    = 3'b001,
    S2    = 3'b010,
    S3    = 3'b011,
    S4    = 3'b100,
    S5    = 3'b101,
    S6    = 3'b110,
    S_ILL = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           st [4];
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       ptr;
  logic [1:0]       last_ch;
  logic [3:0]       elig;
  logic             gvalid;
  logic [1:0]       gidx;
  state_t           cur_st;
  state_t           nxt_st;
  logic             nxt_det;

  // Shared next-state function of the overlapping 10X0 detector.
  function automatic state_t next_state(input state_t s, input logic b);
    state_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S4 : S3;
      S3:      n = b ? S1 : S5;
      S4:      n = b ? S1 : S6;
      S5:      n = b ? S1 : S0;
      S6:      n = b ? S4 : S3;
      default: n = b ? S1 : S0;
    endcase
    return n;
  endfunction

  // Round-robin search starting one past the last granted channel.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] e, input logic [1:0] p);
    logic       found;
    logic [1:0] sel;
    logic [1:0] i;
    found = 1'b0;
    sel   = p;
    for (int k = 1; k <= 4; k++) begin
      i = p + 2'(k);
      if (!found && e[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end
    return {found, sel};
  endfunction

  // Reset masks eligibility so nothing is granted while Rst is high.
  assign elig = Req & Ch_En & {4{~Rst}};

  // Grant decode and the shared next-state evaluation for the granted channel.
  always_comb begin
    {gvalid, gidx} = rr_pick(elig, ptr);
    Gnt     = gvalid ? (4'b0001 << gidx) : 4'b0000;
    cur_st  = st[gidx];
    nxt_st  = next_state(cur_st, Din[gidx]);
    nxt_det = gvalid && ((nxt_st == S5) || (nxt_st == S6));
    CS      = gvalid ? cur_st : S0;
    NS      = gvalid ? nxt_st : S0;
    Gnt_Ch  = gvalid ? gidx : last_ch;
    Cnt_Out = cnt[Cnt_Sel];
  end

  // Moore detect outputs decoded straight from the stored states.
  always_comb begin
    OP = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      OP[c] = (st[c] == S5) || (st[c] == S6);
    end
  end

  // Channel states, counters, round-robin pointer and last-grant index.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int c = 0; c < 4; c++) begin
        st[c]  <= S0;
        cnt[c] <= '0;
      end
      ptr     <= 2'd3;
      last_ch <= 2'd0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (!Ch_En[c]) begin
          st[c] <= S0;
        end else if (gvalid && (gidx == 2'(c))) begin
          st[c] <= nxt_st;
        end
        if (Cnt_Clr && (Cnt_Sel == 2'(c))) begin
          cnt[c] <= '0;
        end else if (nxt_det && (gidx == 2'(c)) && (cnt[c] != CNT_MAX)) begin
          cnt[c] <= cnt[c] + CNT_ONE;
        end
      end
      if (gvalid) begin
        ptr     <= gidx;
        last_ch <= gidx;
      end
    end
  end

endmodule
